// File: rtl/tf32_pkg.sv
// Shared TF32 definitions: field layout, bias, quotient width and the
// sequential divider's state encoding, plus field-extraction helpers.
package tf32_pkg;

  localparam int          EXP_W   = 8;
  localparam int          MAN_W   = 10;
  localparam int          BIAS    = 127;
  localparam int          QW      = MAN_W + 2;
  localparam int          TF_W    = 1 + EXP_W + MAN_W;
  localparam int          EW      = EXP_W + 2;
  localparam logic [7:0]  INF_EXP = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  function automatic logic tf_sign(input logic [TF_W-1:0] v);
    return v[TF_W-1];
  endfunction

  function automatic logic [EXP_W-1:0] tf_exp(input logic [TF_W-1:0] v);
    return v[TF_W-2:MAN_W];
  endfunction

  function automatic logic [MAN_W-1:0] tf_man(input logic [TF_W-1:0] v);
    return v[MAN_W-1:0];
  endfunction

endpackage

// File: rtl/tf32_div_norm.sv
// Combinational normalisation of a restoring-division quotient into a
// 19-bit TF32 result. Truncating, exponent wraps modulo 256.
module tf32_div_norm
  import tf32_pkg::*;
(
  input  logic            s,
  input  logic [EW-1:0]   e,
  input  logic [QW-1:0]   q,
  output logic [TF_W-1:0] res
);

  logic [EXP_W-1:0] e_b;

  // Quotient lies in (0.5, 2): leading bit picks the exponent adjust and fraction window
  always_comb begin
    if (q[QW-1]) begin
      e_b = EXP_W'(e + EW'(BIAS));
      res = {s, e_b, q[QW-2:1]};
    end else begin
      e_b = EXP_W'(e + EW'(BIAS - 1));
      res = {s, e_b, q[QW-3:0]};
    end
  end

endmodule

// File: rtl/fd_tf32_seq.sv
// Iterative TF32 divider (num1/num2), restoring, one quotient bit per cycle,
// ready/valid on both sides.
// Optional build macro TF32_APPROX_DIV_EN: shortens the iteration count from
// the exponent range and leaves the skipped low quotient bits at zero.
//
// state   | meaning
// IDLE    | in_ready=1, waiting for operands
// DIV     | one restoring step per cycle, MSB first
// NORM    | pack quotient/exponent/sign into the result register
// DONE    | out_valid=1, result held until out_ready
module fd_tf32_seq
  import tf32_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [TF_W-1:0] num1,
  input  logic [TF_W-1:0] num2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [TF_W-1:0] out,
  output logic            div_by_zero
);

  div_state_e      state_q, state_d;
  logic            s_q, s_d;
  logic [EW-1:0]   e_q, e_d;
  logic [MAN_W:0]  d_q, d_d;
  logic [QW-1:0]   r_q, r_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [QW-1:0]   q_q, q_d;
  logic [TF_W-1:0] out_q, out_d;
  logic            dz_q, dz_d;

  logic [TF_W-1:0] norm_res;
  logic [3:0]      last_cnt;
  logic [3:0]      bit_idx;
  logic [QW-1:0]   r_diff;

  tf32_div_norm u_norm (
    .s   (s_q),
    .e   (e_q),
    .q   (q_q),
    .res (norm_res)
  );

`ifdef TF32_APPROX_DIV_EN
  logic [3:0] rg;
  logic [3:0] k;

  // Exponent range sets how many quotient bits are worth computing
  always_comb begin
    rg       = e_q[7:4];
    k        = (rg <= 4'd7) ? rg : (4'd15 - rg);
    last_cnt = 4'(QW - 1) - k;
  end
`else
  assign last_cnt = 4'(QW - 1);
`endif

  assign bit_idx = 4'(QW - 1) - cnt_q;
  assign r_diff  = r_q - {1'b0, d_q};

  // State and datapath registers; reset aborts any division in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s_q     <= 1'b0;
      e_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      out_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      e_q     <= e_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      out_q   <= out_d;
      dz_q    <= dz_d;
    end
  end

  // Next state and next datapath values
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    e_d     = e_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    out_d   = out_q;
    dz_d    = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          s_d   = tf_sign(num1) ^ tf_sign(num2);
          e_d   = {2'b0, tf_exp(num1)} - {2'b0, tf_exp(num2)};
          d_d   = {1'b1, tf_man(num2)};
          r_d   = {2'b01, tf_man(num1)};
          cnt_d = '0;
          q_d   = '0;
          dz_d  = 1'b0;
          if (tf_exp(num2) == '0) begin
            out_d   = {s_d, INF_EXP, {MAN_W{1'b0}}};
            dz_d    = 1'b1;
            state_d = ST_DONE;
          end else if (tf_exp(num1) == '0) begin
            out_d   = {s_d, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
            state_d = ST_DONE;
          end else begin
            state_d = ST_DIV;
          end
        end
      end
      ST_DIV: begin
        if (r_q >= {1'b0, d_q}) begin
          q_d[bit_idx] = 1'b1;
          r_d          = {r_diff[QW-2:0], 1'b0};
        end else begin
          r_d          = {r_q[QW-2:0], 1'b0};
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == last_cnt) state_d = ST_NORM;
      end
      ST_NORM: begin
        out_d   = norm_res;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decode directly from state
  always_comb begin
    in_ready    = (state_q == ST_IDLE);
    out_valid   = (state_q == ST_DONE);
    out         = out_q;
    div_by_zero = dz_q;
  end

endmodule

// File: tb/tb_fd_tf32_seq.sv
// Directed bench for fd_tf32_seq: hand-computed quotients, latency,
// backpressure and asynchronous reset abort.
module tb_fd_tf32_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [18:0] num1;
  logic [18:0] num2;
  logic        out_valid;
  logic        out_ready;
  logic [18:0] out;
  logic        div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  fd_tf32_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .num1        (num1),
    .num2        (num2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out         (out),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Present operands for one cycle, then wait for out_valid; lat counts
  // clock edges after the accept edge before out_valid is visible.
  task automatic start_and_wait(input logic [18:0] a, input logic [18:0] b,
                                input logic [18:0] exp_out, input logic exp_dz,
                                input int exp_lat, input string tag);
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    num1     = a;
    num2     = b;
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    num1     = 19'h7FFFF;
    num2     = 19'h55555;
    lat      = 0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_out"}, 32'(out), 32'(exp_out));
    check_eq({tag, "_dz"}, 32'(div_by_zero), 32'(exp_dz));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check_eq({tag, "_valid_clr"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    num1      = '0;
    num2      = '0;
    #12;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out", 32'(out), 32'd0);
    check_eq("rst_dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 6.0/2.0 = 3.0
    start_and_wait(19'h20600, 19'h20000, 19'h20200, 1'b0, 13, "div_6_2");
    release_out("div_6_2");
    // 1.0/3.0, leading quotient bit clear, truncated fraction 0x155
    start_and_wait(19'h1FC00, 19'h20200, 19'h1F555, 1'b0, 13, "div_1_3");
    release_out("div_1_3");
    // -6.0/2.0 = -3.0
    start_and_wait(19'h60600, 19'h20000, 19'h60200, 1'b0, 13, "div_m6_2");
    release_out("div_m6_2");
    // 1.0/0 -> +inf pattern, visible in the cycle right after accept
    start_and_wait(19'h1FC00, 19'h00000, 19'h3FC00, 1'b1, 0, "div_1_0");
    release_out("div_1_0");
    // 0/2.0 -> zero, no div-by-zero flag
    start_and_wait(19'h40000, 19'h20000, 19'h40000, 1'b0, 0, "div_0_2");
    release_out("div_0_2");

    // Backpressure: hold DONE for 5 cycles while offering a new operand
    start_and_wait(19'h20600, 19'h20000, 19'h20200, 1'b0, 13, "bp");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      num1     = 19'h1FC00;
      num2     = 19'h00000;
      @(negedge clk);
      check_eq("bp_out_hold", 32'(out), 32'h20200);
      check_eq("bp_valid_hold", 32'(out_valid), 32'd1);
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
      check_eq("bp_dz_hold", 32'(div_by_zero), 32'd0);
    end
    in_valid = 1'b0;
    release_out("bp");
    check_eq("bp_out_after", 32'(out), 32'h20200);

    // Reset in the middle of DIV aborts the operation
    @(negedge clk);
    in_valid = 1'b1;
    num1     = 19'h20600;
    num2     = 19'h20000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    check_eq("pre_rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("mid_rst_out", 32'(out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_valid", 32'(out_valid), 32'd0);
    start_and_wait(19'h1FC00, 19'h1FC00, 19'h1FC00, 1'b0, 13, "div_1_1");
    release_out("div_1_1");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
